// File: rtl/sound_trigger_pio.sv
// Avalon-MM trigger port for the external audio player: fires a sound ID as a
// programmable-length pulse, then waits for the player's done handshake.
module sound_trigger_pio #(
   parameter int ID_W          = 4,
   parameter int LEN_W         = 16,
   parameter int PULSE_DEFAULT = 50000
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [1:0]      address,
   input  logic            chipselect,
   input  logic            write_n,
   input  logic [15:0]     writedata,
   output logic [15:0]     readdata,
   input  logic            sound_done,
   output logic            out_port,
   output logic [ID_W-1:0] sound_id,
   output logic            irq
);

   typedef enum logic [1:0] {IDLE, PULSE, WAIT_DONE} state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_cnt;
   logic [LEN_W-1:0]  w_cnt_nxt;
   logic [ID_W-1:0]   r_id;
   logic              r_out;
   logic              r_dropped;
   logic              r_done;
   logic              r_irq_en;
   logic              r_irq;
   logic              r_sync1;
   logic              r_sync2;
   logic              r_prev;
   logic [15:0]       r_rdata;
   logic [15:0]       w_rmux;

   logic w_wr;
   logic w_cmd_wr;
   logic w_len_wr;
   logic w_st_wr;
   logic w_ctl_wr;
   logic w_abort;
   logic w_accept;
   logic w_done_edge;
   logic w_done_set;
   logic w_drop_set;

   assign w_wr        = chipselect & ~write_n;
   assign w_cmd_wr    = w_wr & (address == 2'd0);
   assign w_len_wr    = w_wr & (address == 2'd1);
   assign w_st_wr     = w_wr & (address == 2'd2);
   assign w_ctl_wr    = w_wr & (address == 2'd3);
   assign w_abort     = w_st_wr & writedata[3] & (r_state != IDLE);
   assign w_done_edge = r_sync2 & ~r_prev;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_drop_set  = 1'b0;
      w_done_set  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_cmd_wr) begin
               w_accept    = 1'b1;
               w_state_nxt = PULSE;
               w_cnt_nxt   = (r_len == '0) ? LEN_W'(1) : r_len;
            end
         end
         PULSE: begin
            w_drop_set = w_cmd_wr;
            if (w_abort)
               w_state_nxt = IDLE;
            else if (r_cnt == LEN_W'(1))
               w_state_nxt = WAIT_DONE;
            else
               w_cnt_nxt = r_cnt - LEN_W'(1);
         end
         WAIT_DONE: begin
            w_drop_set = w_cmd_wr;
            // abort takes priority over a coincident completion
            if (w_abort) begin
               w_state_nxt = IDLE;
            end else if (w_done_edge) begin
               w_state_nxt = IDLE;
               w_done_set  = 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_out   <= 1'b0;
         r_id    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_out   <= (w_state_nxt == PULSE);
         if (w_accept) r_id <= writedata[ID_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= sound_done;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   // sticky flags: a set in the same cycle as its W1C clear wins
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_len     <= LEN_W'(PULSE_DEFAULT);
         r_dropped <= 1'b0;
         r_done    <= 1'b0;
         r_irq_en  <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         if (w_len_wr) r_len <= writedata[LEN_W-1:0];
         if (w_drop_set)
            r_dropped <= 1'b1;
         else if (w_st_wr & writedata[1])
            r_dropped <= 1'b0;
         if (w_done_set)
            r_done <= 1'b1;
         else if (w_st_wr & writedata[2])
            r_done <= 1'b0;
         if (w_ctl_wr) r_irq_en <= writedata[0];
         r_irq <= r_done & r_irq_en;
      end
   end

   always_comb begin
      w_rmux = '0;
      unique case (address)
         2'd0: w_rmux[ID_W-1:0]  = r_id;
         2'd1: w_rmux[LEN_W-1:0] = r_len;
         2'd2: w_rmux[2:0]       = {r_done, r_dropped, r_state != IDLE};
         2'd3: w_rmux[0]         = r_irq_en;
         default: w_rmux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_rdata <= '0;
      else          r_rdata <= w_rmux;
   end

   assign readdata = r_rdata;
   assign out_port = r_out;
   assign sound_id = r_id;
   assign irq      = r_irq;

endmodule

// File: tb/tb_sound_trigger_pio.sv
// Scoreboard bench for sound_trigger_pio: reads, pulse widths and irq
// transitions are queued by stimulus and checked by independent monitors.
module tb_sound_trigger_pio;

   typedef struct {
      logic [15:0] v;
      string       n;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'd0;
   logic [15:0] readdata;
   logic        sound_done = 1'b0;
   logic        out_port;
   logic [3:0]  sound_id;
   logic        irq;

   exp_t rd_q[$];
   exp_t pl_q[$];
   exp_t irq_q[$];
   logic rd_issue = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   sound_trigger_pio dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .sound_done (sound_done),
      .out_port   (out_port),
      .sound_id   (sound_id),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", n, act, exp);
      end
   endtask

   task automatic rd(input logic [1:0] a, input logic [15:0] e,
                     input string n);
      exp_t x;
      @(posedge clk); #1;
      address = a;
      x.v = e; x.n = n;
      rd_q.push_back(x);
      rd_issue = 1'b1;
      @(posedge clk); #1;
      rd_issue = 1'b0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      @(posedge clk); #1;
      address = a; writedata = d;
      chipselect = 1'b1; write_n = 1'b0;
      @(posedge clk); #1;
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic exp_pulse(input int w, input string n);
      exp_t x;
      x.v = 16'(w); x.n = n;
      pl_q.push_back(x);
   endtask

   task automatic exp_irq(input logic v, input string n);
      exp_t x;
      x.v = {15'd0, v}; x.n = n;
      irq_q.push_back(x);
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // read monitor: readdata is valid one cycle after address
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         if (rd_issue) begin
            @(negedge clk);
            if (rd_q.size() == 0) begin
               cmp("rd_unexpected", readdata, 32'hFFFF_FFFF);
            end else begin
               x = rd_q.pop_front();
               cmp(x.n, readdata, x.v);
            end
         end
      end
   end

   // pulse monitor: measures each high run of out_port in cycles
   initial begin
      exp_t x;
      int   w;
      w = 0;
      forever begin
         @(negedge clk);
         if (out_port === 1'b1) begin
            w++;
         end else if (w > 0) begin
            if (pl_q.size() == 0) begin
               cmp("pulse_unexpected", w, 0);
            end else begin
               x = pl_q.pop_front();
               cmp(x.n, w, x.v);
            end
            w = 0;
         end
      end
   end

   // irq monitor: every change of irq must match the next expected value
   initial begin
      exp_t x;
      logic p;
      p = 1'b0;
      forever begin
         @(negedge clk);
         if (irq !== p) begin
            if (irq_q.size() == 0) begin
               cmp("irq_unexpected", irq, p);
            end else begin
               x = irq_q.pop_front();
               cmp(x.n, irq, x.v);
            end
            p = irq;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      #1 reset_n = 1'b0;
      cyc(3);
      reset_n = 1'b1;
      cyc(1);

      cmp("rst_out_port", out_port, 0);
      rd(2'd1, 16'd50000, "rst_len");
      rd(2'd0, 16'd0, "rst_cmd");
      rd(2'd2, 16'd0, "rst_status");
      rd(2'd3, 16'd0, "rst_ctrl");

      // 5-cycle pulse, ID 7, then completion with irq
      wr(2'd1, 16'd5);
      exp_pulse(5, "pulse_len5");
      wr(2'd0, 16'h7);
      rd(2'd2, 16'h1, "busy_in_pulse");
      rd(2'd0, 16'd7, "id7");
      cyc(6);
      rd(2'd2, 16'h1, "busy_wait_done");
      wr(2'd3, 16'h1);
      sound_done = 1'b1;
      exp_irq(1'b1, "irq_rise");
      cyc(5);
      rd(2'd2, 16'h4, "done_flag_set");
      rd(2'd3, 16'h1, "ctrl_irq_en");
      exp_irq(1'b0, "irq_fall");
      wr(2'd2, 16'h4);
      rd(2'd2, 16'h0, "done_cleared");

      // command while busy is dropped
      wr(2'd3, 16'h0);
      sound_done = 1'b0;
      wr(2'd1, 16'd8);
      exp_pulse(8, "pulse_len8_drop");
      wr(2'd0, 16'h7);
      wr(2'd0, 16'h3);
      rd(2'd0, 16'd7, "id_kept_on_drop");
      rd(2'd2, 16'h3, "dropped_set");
      wr(2'd2, 16'h2);
      rd(2'd2, 16'h1, "dropped_cleared");
      sound_done = 1'b1;
      cyc(5);
      rd(2'd2, 16'h4, "done_after_drop");
      wr(2'd2, 16'h4);
      sound_done = 1'b0;
      cyc(4);

      // zero length -> 1 cycle; abort in WAIT_DONE; stale done level
      sound_done = 1'b1;
      cyc(4);
      wr(2'd1, 16'd0);
      exp_pulse(1, "pulse_len0");
      wr(2'd0, 16'h1);
      cyc(3);
      rd(2'd2, 16'h1, "stale_level_no_done");
      rd(2'd0, 16'd1, "id1");
      wr(2'd2, 16'h8);
      rd(2'd2, 16'h0, "abort_idle");
      rd(2'd0, 16'd1, "id_kept_abort");
      sound_done = 1'b0;
      cyc(4);
      sound_done = 1'b1;
      cyc(5);
      rd(2'd2, 16'h0, "edge_in_idle_ignored");
      wr(2'd1, 16'd2);
      exp_pulse(2, "pulse_len2");
      wr(2'd0, 16'h4);
      cyc(4);
      rd(2'd2, 16'h1, "held_high_waits");
      sound_done = 1'b0;
      cyc(4);
      sound_done = 1'b1;
      cyc(5);
      rd(2'd2, 16'h4, "fresh_edge_done");
      rd(2'd0, 16'd4, "id4");

      // done set and W1C clear in the same cycle: set wins
      wr(2'd2, 16'h4);
      sound_done = 1'b0;
      cyc(4);
      wr(2'd1, 16'd1);
      exp_pulse(1, "pulse_len1");
      wr(2'd0, 16'h2);
      cyc(3);
      @(posedge clk); #1;
      sound_done = 1'b1;
      @(posedge clk); #1;
      wr(2'd2, 16'h4);
      rd(2'd2, 16'h4, "set_beats_clear");

      // asynchronous reset mid-pulse
      sound_done = 1'b0;
      cyc(4);
      wr(2'd1, 16'd10);
      exp_pulse(3, "pulse_cut_by_reset");
      wr(2'd0, 16'h9);
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b0;
      #1 cmp("async_out_port", out_port, 0);
      cyc(2);
      reset_n = 1'b1;
      rd(2'd1, 16'd50000, "len_after_reset");
      rd(2'd2, 16'h0, "status_after_reset");
      rd(2'd0, 16'd0, "id_after_reset");
      rd(2'd3, 16'd0, "ctrl_after_reset");
      cyc(4);

      cmp("rd_q_drained", rd_q.size(), 0);
      cmp("pulse_q_drained", pl_q.size(), 0);
      cmp("irq_q_drained", irq_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
